// File: rtl/fde_sequencer.sv
// fde_sequencer: fetch-decode-execute sequencer with ROM/execute handshakes, PC redirection, halt and retire count
module fde_sequencer #(
  parameter int PC_WIDTH = 16,
  parameter int INSTR_WIDTH = 41,
  parameter int OPCODE_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    rom_req,
  output logic [PC_WIDTH-1:0]     rom_addr,
  input  logic                    rom_ack,
  input  logic [INSTR_WIDTH-1:0]  rom_data,
  output logic [INSTR_WIDTH-1:0]  ir,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    decode_valid,
  output logic                    exec_start,
  input  logic                    exec_done,
  input  logic                    branch_taken,
  input  logic [PC_WIDTH-1:0]     branch_target,
  input  logic                    halt_req,
  output logic                    halted,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [COUNT_WIDTH-1:0]  retired
);
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;
  state_t state, state_nx;
  logic retire;
  always_comb begin
    retire = (state == EXECUTE) && exec_done;
    state_nx = (state == FETCH)   ? (rom_ack ? DECODE : FETCH) :
               (state == DECODE)  ? EXECUTE :
               (state == EXECUTE) ? (exec_done ? (halt_req ? HALT : FETCH) : EXECUTE) :
                                    HALT;
  end
  assign rom_req = (state == FETCH);
  assign rom_addr = pc;
  // decode_valid and exec_start both fire in the first EXECUTE cycle, when opcode lands
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      opcode <= '0;
      decode_valid <= 1'b0;
      exec_start <= 1'b0;
      halted <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nx;
      decode_valid <= (state == DECODE);
      exec_start <= (state == DECODE);
      halted <= (state_nx == HALT);
      if (state == FETCH && rom_ack) ir <= rom_data;
      if (state == DECODE) opcode <= ir[OPCODE_WIDTH-1:0];
      if (retire) begin
        pc <= branch_taken ? branch_target : pc + 1'b1;
        retired <= retired + 1'b1;
      end
    end
  end
endmodule
